dispatch_queue: RTL

DISPATCH_QUEUE -- requirements
Module: dispatch_queue

---
 rtl/dispatch_queue_pkg.sv | 14 +
 rtl/dispatch_slot_mux.sv | 30 +++
 rtl/dispatch_queue.sv | 86 ++++++++
 3 files changed

// File: rtl/dispatch_queue_pkg.sv
// Shared widths and defaults for the dispatch queue and the issue buffer that consumes it.
// The slot-count width must match on both sides, so it is derived in one place.
package dispatch_queue_pkg;

   localparam int DEFAULT_DATA_WIDTH = 47;
   localparam int DEFAULT_PUSH_WIDTH = 4;
   localparam int DEFAULT_DEPTH      = 8;

   // Width of a slot count that can express 0..push_width inclusive.
   function automatic int ct_width(input int push_width);
      return $clog2(push_width) + 1;
   endfunction

endpackage

// File: rtl/dispatch_slot_mux.sv
// Presents up to PUSH_WIDTH queue entries, oldest first, read relative to rd_ptr.
// Slots beyond valid_ct are forced to zero so the consumer never sees stale storage.
module dispatch_slot_mux
   import dispatch_queue_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int PUSH_WIDTH = DEFAULT_PUSH_WIDTH,
   parameter int DEPTH      = DEFAULT_DEPTH
) (
   input  logic [DATA_WIDTH-1:0]            mem [DEPTH],
   input  logic [$clog2(DEPTH)-1:0]         rd_ptr,
   input  logic [ct_width(PUSH_WIDTH)-1:0]  valid_ct,
   output logic [DATA_WIDTH*PUSH_WIDTH-1:0] dout
);

   localparam int CT_W  = ct_width(PUSH_WIDTH);
   localparam int PTR_W = $clog2(DEPTH);

   // NOTE: dout gets a default before the loop so no path leaves it unassigned (no latch).
   always_comb begin
      dout = '0;
      for (int k = 0; k < PUSH_WIDTH; k++) begin
         // DEPTH is a power of two, so the PTR_W-bit sum wraps modulo DEPTH for free.
         if (CT_W'(k) < valid_ct) begin
            dout[k*DATA_WIDTH +: DATA_WIDTH] = mem[rd_ptr + PTR_W'(k)];
         end
      end
   end

endmodule

// File: rtl/dispatch_queue.sv
// Decode-to-issue dispatch queue: one instruction in per cycle, up to PUSH_WIDTH out per cycle.
// Circular buffer with occupancy counter; outputs depend only on registered state.
module dispatch_queue
   import dispatch_queue_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int PUSH_WIDTH = DEFAULT_PUSH_WIDTH,
   parameter int DEPTH      = DEFAULT_DEPTH
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             flush,
   input  logic [DATA_WIDTH-1:0]            din,
   input  logic                             din_valid,
   output logic                             din_ready,
   output logic [DATA_WIDTH*PUSH_WIDTH-1:0] dout,
   output logic [ct_width(PUSH_WIDTH)-1:0]  dout_valid_ct,
   input  logic [ct_width(PUSH_WIDTH)-1:0]  dout_ready_ct,
   output logic [$clog2(DEPTH):0]           count
);

   localparam int CT_W  = ct_width(PUSH_WIDTH);
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int PTR_W = $clog2(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0]      rd_ptr_q;
   logic [PTR_W-1:0]      wr_ptr_q;
   logic [CNT_W-1:0]      count_q;

   logic [CT_W-1:0]       valid_ct;
   logic [CT_W-1:0]       ready_sat;
   logic [CT_W-1:0]       pop_n;
   logic                  push;

   // Full is judged before any same-cycle pop, keeping din_ready off the consumer path.
   assign din_ready = (count_q < CNT_W'(DEPTH));
   assign push      = din_valid && din_ready;
   assign count     = count_q;

   always_comb begin
      valid_ct  = (count_q >= CNT_W'(PUSH_WIDTH)) ? CT_W'(PUSH_WIDTH) : CT_W'(count_q);
      ready_sat = (dout_ready_ct > CT_W'(PUSH_WIDTH)) ? CT_W'(PUSH_WIDTH) : dout_ready_ct;
      pop_n     = (ready_sat < valid_ct) ? ready_sat : valid_ct;
   end

   assign dout_valid_ct = valid_ct;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         count_q  <= count_q + CNT_W'(push) - CNT_W'(pop_n);
         rd_ptr_q <= rd_ptr_q + PTR_W'(pop_n);
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
      end
   end

   // NOTE: storage has no reset; entries are only visible through count, so stale data is harmless.
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem[wr_ptr_q] <= din;
      end
   end

   dispatch_slot_mux #(
      .DATA_WIDTH (DATA_WIDTH),
      .PUSH_WIDTH (PUSH_WIDTH),
      .DEPTH      (DEPTH)
   ) u_slot_mux (
      .mem      (mem),
      .rd_ptr   (rd_ptr_q),
      .valid_ct (valid_ct),
      .dout     (dout)
   );

endmodule
